// File: rtl/cpu_defs_pkg.sv
// Shared CPU encodings: ALU control codes and the MIPS opcode/funct values the ID stage decodes.
package cpu_defs_pkg;

  localparam logic [4:0] ALUC_NOP  = 5'd0;
  localparam logic [4:0] ALUC_ADD  = 5'd1;
  localparam logic [4:0] ALUC_SUB  = 5'd2;
  localparam logic [4:0] ALUC_AND  = 5'd3;
  localparam logic [4:0] ALUC_OR   = 5'd4;
  localparam logic [4:0] ALUC_XOR  = 5'd5;
  localparam logic [4:0] ALUC_SLL  = 5'd6;
  localparam logic [4:0] ALUC_SRL  = 5'd7;
  localparam logic [4:0] ALUC_SRA  = 5'd8;
  localparam logic [4:0] ALUC_ADDI = 5'd10;
  localparam logic [4:0] ALUC_ANDI = 5'd11;
  localparam logic [4:0] ALUC_ORI  = 5'd12;
  localparam logic [4:0] ALUC_XORI = 5'd13;
  localparam logic [4:0] ALUC_LW   = 5'd14;
  localparam logic [4:0] ALUC_SW   = 5'd15;
  localparam logic [4:0] ALUC_BEQ  = 5'd16;
  localparam logic [4:0] ALUC_BNE  = 5'd17;
  localparam logic [4:0] ALUC_LUI  = 5'd18;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;

endpackage

// File: rtl/id_decode_stage_if.sv
// IF/ID-side inputs and ID/EX-side outputs of the decode stage; illegal-trap signals exist only
// when ILLEGAL_TRAP_EN is defined.
interface id_decode_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int ALUC_W = 5
) ();
  logic              id_valid;
  logic [DATA_W-1:0] id_instr;
  logic [DATA_W-1:0] id_pc;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              ex_ready;

  logic              id_stall;
  logic              br_taken;
  logic [DATA_W-1:0] br_target;
  logic              ex_valid;
  logic [ALUC_W-1:0] ex_aluc;
  logic [DATA_W-1:0] ex_data1;
  logic [DATA_W-1:0] ex_data2;
  logic [DATA_W-1:0] ex_store;
  logic              ex_wreg;
  logic [REG_AW-1:0] ex_waddr;
  logic              ex_mem_rd;
  logic              ex_mem_wr;
`ifdef ILLEGAL_TRAP_EN
  logic              illegal_flag;
  logic [DATA_W-1:0] illegal_pc;
`endif

  modport master (
    output id_valid, id_instr, id_pc, rs_data, rt_data, ex_ready,
    input  id_stall, br_taken, br_target, ex_valid, ex_aluc, ex_data1, ex_data2,
           ex_store, ex_wreg, ex_waddr, ex_mem_rd, ex_mem_wr
`ifdef ILLEGAL_TRAP_EN
           , illegal_flag, illegal_pc
`endif
  );

  modport slave (
    input  id_valid, id_instr, id_pc, rs_data, rt_data, ex_ready,
    output id_stall, br_taken, br_target, ex_valid, ex_aluc, ex_data1, ex_data2,
           ex_store, ex_wreg, ex_waddr, ex_mem_rd, ex_mem_wr
`ifdef ILLEGAL_TRAP_EN
           , illegal_flag, illegal_pc
`endif
  );
endinterface

// File: rtl/id_hazard_unit.sv
// Load-use detection against the instruction sitting in ID/EX, plus stall and issue generation.
module id_hazard_unit #(
  parameter int REG_AW = 5
) (
  input  logic              id_valid,
  input  logic              ex_ready,
  input  logic              use_rs,
  input  logic              use_rt,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  input  logic              ex_valid,
  input  logic              ex_mem_rd,
  input  logic [REG_AW-1:0] ex_waddr,
  output logic              id_stall,
  output logic              issue
);
  logic rs_hit, rt_hit, load_use;

  assign rs_hit   = use_rs && (rs_addr == ex_waddr);
  assign rt_hit   = use_rt && (rt_addr == ex_waddr);
  // The bubble clears ex_mem_rd, so this can only fire for one cycle per load.
  assign load_use = id_valid && ex_valid && ex_mem_rd && (ex_waddr != '0) && (rs_hit || rt_hit);

  assign id_stall = !ex_ready || load_use;
  assign issue    = id_valid && !id_stall;
endmodule

// File: rtl/id_decode_stage.sv
// MIPS ID stage: decode to aluc/operands, early beq/bne resolution, load-use stall, ID/EX register.
// Optional ILLEGAL_TRAP_EN adds a sticky illegal-opcode flag and the PC of the first offender.
module id_decode_stage
  import cpu_defs_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int ALUC_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  id_decode_stage_if.slave  bus
);
  logic [5:0]        op, funct;
  logic [4:0]        rs, rt, rd, shamt;
  logic [15:0]       imm;
  logic [DATA_W-1:0] imm_sext, imm_zext, shamt_ext, br_off;

  assign op        = bus.id_instr[31:26];
  assign rs        = bus.id_instr[25:21];
  assign rt        = bus.id_instr[20:16];
  assign rd        = bus.id_instr[15:11];
  assign shamt     = bus.id_instr[10:6];
  assign funct     = bus.id_instr[5:0];
  assign imm       = bus.id_instr[15:0];
  assign imm_sext  = {{(DATA_W-16){imm[15]}}, imm};
  assign imm_zext  = {{(DATA_W-16){1'b0}}, imm};
  assign shamt_ext = {{(DATA_W-5){1'b0}}, shamt};
  assign br_off    = {{(DATA_W-18){imm[15]}}, imm, 2'b00};

  logic [ALUC_W-1:0] dec_aluc;
  logic [DATA_W-1:0] dec_d1, dec_d2;
  logic [REG_AW-1:0] dest, dec_waddr;
  logic              wr_en, dec_wreg, dec_mrd, dec_mwr, use_rs, use_rt, dec_illegal;

  always_comb begin
    dec_aluc    = ALUC_NOP;
    dec_d1      = bus.rs_data;
    dec_d2      = bus.rt_data;
    dest        = '0;
    wr_en       = 1'b0;
    dec_mrd     = 1'b0;
    dec_mwr     = 1'b0;
    use_rs      = 1'b0;
    use_rt      = 1'b0;
    dec_illegal = 1'b0;
    // The all-zero word is the canonical nop, not "sll $0,$0,0".
    if (bus.id_instr != '0) begin
      case (op)
        OP_RTYPE: begin
          dest   = rd;
          wr_en  = 1'b1;
          use_rs = 1'b1;
          use_rt = 1'b1;
          case (funct)
            FUNCT_ADD, FUNCT_ADDU: dec_aluc = ALUC_ADD;
            FUNCT_SUB, FUNCT_SUBU: dec_aluc = ALUC_SUB;
            FUNCT_AND:             dec_aluc = ALUC_AND;
            FUNCT_OR:              dec_aluc = ALUC_OR;
            FUNCT_XOR:             dec_aluc = ALUC_XOR;
            FUNCT_SLL, FUNCT_SRL, FUNCT_SRA: begin
              dec_aluc = (funct == FUNCT_SLL) ? ALUC_SLL :
                         (funct == FUNCT_SRL) ? ALUC_SRL : ALUC_SRA;
              dec_d1   = shamt_ext;
              use_rs   = 1'b0;
            end
            default: begin
              wr_en       = 1'b0;
              use_rs      = 1'b0;
              use_rt      = 1'b0;
              dec_illegal = 1'b1;
            end
          endcase
        end
        OP_ADDI, OP_ADDIU: begin
          dec_aluc = ALUC_ADDI;
          dec_d2   = imm_sext;
          dest     = rt;
          wr_en    = 1'b1;
          use_rs   = 1'b1;
        end
        OP_ANDI, OP_ORI, OP_XORI: begin
          dec_aluc = (op == OP_ANDI) ? ALUC_ANDI :
                     (op == OP_ORI)  ? ALUC_ORI  : ALUC_XORI;
          dec_d2   = imm_zext;
          dest     = rt;
          wr_en    = 1'b1;
          use_rs   = 1'b1;
        end
        OP_LW: begin
          dec_aluc = ALUC_LW;
          dec_d2   = imm_sext;
          dest     = rt;
          wr_en    = 1'b1;
          dec_mrd  = 1'b1;
          use_rs   = 1'b1;
        end
        OP_SW: begin
          dec_aluc = ALUC_SW;
          dec_d2   = imm_sext;
          dec_mwr  = 1'b1;
          use_rs   = 1'b1;
          use_rt   = 1'b1;
        end
        OP_BEQ, OP_BNE: begin
          dec_aluc = (op == OP_BEQ) ? ALUC_BEQ : ALUC_BNE;
          use_rs   = 1'b1;
          use_rt   = 1'b1;
        end
        OP_LUI: begin
          dec_aluc = ALUC_LUI;
          dec_d2   = imm_zext;
          dest     = rt;
          wr_en    = 1'b1;
        end
        default: dec_illegal = 1'b1;
      endcase
    end
  end

  // $0 is never a real destination; keep waddr clean when nothing is written.
  assign dec_wreg  = wr_en && (dest != '0);
  assign dec_waddr = dec_wreg ? dest : '0;

  logic              ex_valid_q, ex_wreg_q, ex_mrd_q, ex_mwr_q;
  logic [ALUC_W-1:0] ex_aluc_q;
  logic [DATA_W-1:0] ex_d1_q, ex_d2_q, ex_st_q;
  logic [REG_AW-1:0] ex_waddr_q;
  logic              id_stall, issue;

  id_hazard_unit #(.REG_AW(REG_AW)) u_hazard (
    .id_valid  (bus.id_valid),
    .ex_ready  (bus.ex_ready),
    .use_rs    (use_rs),
    .use_rt    (use_rt),
    .rs_addr   (rs),
    .rt_addr   (rt),
    .ex_valid  (ex_valid_q),
    .ex_mem_rd (ex_mrd_q),
    .ex_waddr  (ex_waddr_q),
    .id_stall  (id_stall),
    .issue     (issue)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q <= 1'b0;
      ex_aluc_q  <= '0;
      ex_d1_q    <= '0;
      ex_d2_q    <= '0;
      ex_st_q    <= '0;
      ex_wreg_q  <= 1'b0;
      ex_waddr_q <= '0;
      ex_mrd_q   <= 1'b0;
      ex_mwr_q   <= 1'b0;
    end else if (bus.ex_ready) begin
      // Not issuing (empty slot or load-use) loads an all-zero bubble.
      ex_valid_q <= issue;
      ex_aluc_q  <= issue ? dec_aluc    : '0;
      ex_d1_q    <= issue ? dec_d1      : '0;
      ex_d2_q    <= issue ? dec_d2      : '0;
      ex_st_q    <= issue ? bus.rt_data : '0;
      ex_wreg_q  <= issue && dec_wreg;
      ex_waddr_q <= issue ? dec_waddr   : '0;
      ex_mrd_q   <= issue && dec_mrd;
      ex_mwr_q   <= issue && dec_mwr;
    end
  end

  assign bus.id_stall  = id_stall;
  assign bus.br_taken  = issue && (((dec_aluc == ALUC_BEQ) && (bus.rs_data == bus.rt_data)) ||
                                   ((dec_aluc == ALUC_BNE) && (bus.rs_data != bus.rt_data)));
  assign bus.br_target = bus.id_pc + DATA_W'(4) + br_off;
  assign bus.ex_valid  = ex_valid_q;
  assign bus.ex_aluc   = ex_aluc_q;
  assign bus.ex_data1  = ex_d1_q;
  assign bus.ex_data2  = ex_d2_q;
  assign bus.ex_store  = ex_st_q;
  assign bus.ex_wreg   = ex_wreg_q;
  assign bus.ex_waddr  = ex_waddr_q;
  assign bus.ex_mem_rd = ex_mrd_q;
  assign bus.ex_mem_wr = ex_mwr_q;

`ifdef ILLEGAL_TRAP_EN
  logic              ill_flag_q;
  logic [DATA_W-1:0] ill_pc_q;

  // Only an issued instruction counts, so a stalled offender is not recorded twice or early.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ill_flag_q <= 1'b0;
      ill_pc_q   <= '0;
    end else if (issue && dec_illegal && !ill_flag_q) begin
      ill_flag_q <= 1'b1;
      ill_pc_q   <= bus.id_pc;
    end
  end

  assign bus.illegal_flag = ill_flag_q;
  assign bus.illegal_pc   = ill_pc_q;
`else
  logic unused_illegal;
  assign unused_illegal = dec_illegal;
`endif
endmodule

// File: tb/tb_id_decode_stage.sv
// Bench for id_decode_stage: directed vector table, hand sequences, randomized run vs reference model.
module tb_id_decode_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  id_decode_stage_if bus ();
  id_decode_stage dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [4:0] aluc; logic [31:0] d1, d2, st; logic wreg; logic [4:0] waddr;
    logic mrd, mwr, urs, urt, ill;
  } dec_t;
  typedef struct packed {
    logic v; logic [4:0] aluc; logic [31:0] d1, d2, st; logic wreg; logic [4:0] waddr;
    logic mrd, mwr;
  } exr_t;
  typedef struct {
    logic [31:0] ins, pc, a, b; logic [4:0] aluc; logic [31:0] d1, d2;
    logic wreg; logic [4:0] waddr; logic br; logic [31:0] tgt;
  } vec_t;

  exr_t        m;
  logic        m_flag;
  logic [31:0] m_ipc;
  logic [4:0]  r_tab [64];
  logic [4:0]  i_tab [64];
  vec_t        tv [13];
  logic [5:0]  fns [10];
  logic [5:0]  ops [11];
  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_r(input int rs, rt, rd, sh, fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction
  function automatic logic [31:0] enc_i(input int op, rs, rt, input logic [15:0] imm);
    return {6'(op), 5'(rs), 5'(rt), imm};
  endfunction

  // Reference decode: mnemonic lookup tables, then operand/destination rules by code class.
  function automatic dec_t ref_dec(input logic [31:0] ins, a, b);
    dec_t d; logic [4:0] code, dst;
    code = (ins == 32'd0) ? 5'd0 : (ins[31:26] == 6'd0) ? r_tab[ins[5:0]] : i_tab[ins[31:26]];
    d.aluc = code; d.d1 = a; d.d2 = b; d.st = b;
    d.mrd = (code == 5'd14); d.mwr = (code == 5'd15);
    d.ill = (ins != 32'd0) && (code == 5'd0);
    d.urs = code inside {[5'd1:5'd5], [5'd10:5'd17]};
    d.urt = code inside {[5'd1:5'd8], [5'd15:5'd17]};
    if (code inside {[5'd6:5'd8]}) d.d1 = {27'd0, ins[10:6]};
    if (code inside {5'd10, 5'd14, 5'd15}) d.d2 = {{16{ins[15]}}, ins[15:0]};
    if (code inside {[5'd11:5'd13], 5'd18}) d.d2 = {16'd0, ins[15:0]};
    dst = (code inside {[5'd1:5'd8]}) ? ins[15:11] :
          (code inside {[5'd10:5'd14], 5'd18}) ? ins[20:16] : 5'd0;
    d.wreg = (dst != 5'd0); d.waddr = dst;
    return d;
  endfunction

  task automatic chk_regs();
    chk("ex_valid", 32'(bus.ex_valid), 32'(m.v));
    chk("ex_aluc", 32'(bus.ex_aluc), 32'(m.aluc));
    chk("ex_data1", bus.ex_data1, m.d1);
    chk("ex_data2", bus.ex_data2, m.d2);
    chk("ex_store", bus.ex_store, m.st);
    chk("ex_wreg", 32'(bus.ex_wreg), 32'(m.wreg));
    chk("ex_waddr", 32'(bus.ex_waddr), 32'(m.waddr));
    chk("ex_mem_rd", 32'(bus.ex_mem_rd), 32'(m.mrd));
    chk("ex_mem_wr", 32'(bus.ex_mem_wr), 32'(m.mwr));
`ifdef ILLEGAL_TRAP_EN
    chk("illegal_flag", 32'(bus.illegal_flag), 32'(m_flag));
    chk("illegal_pc", bus.illegal_pc, m_ipc);
`endif
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, pc, a, b, input logic rdy);
    bus.id_valid = v; bus.id_instr = ins; bus.id_pc = pc;
    bus.rs_data = a; bus.rt_data = b; bus.ex_ready = rdy;
  endtask

  // One cycle: check combinational outputs, clock, advance model, check ID/EX.
  task automatic step(input logic v, input logic [31:0] ins, pc, a, b, input logic rdy);
    dec_t d; logic lu, stl, br; logic [31:0] tgt;
    drive(v, ins, pc, a, b, rdy);
    #1;
    d   = ref_dec(ins, a, b);
    lu  = v && m.v && m.mrd && (m.waddr != 5'd0) &&
          ((d.urs && ins[25:21] == m.waddr) || (d.urt && ins[20:16] == m.waddr));
    stl = !rdy || lu;
    br  = v && !stl && ((d.aluc == 5'd16 && a == b) || (d.aluc == 5'd17 && a != b));
    tgt = pc + 32'd4 + {{14{ins[15]}}, ins[15:0], 2'b00};
    chk("id_stall", 32'(bus.id_stall), 32'(stl));
    chk("br_taken", 32'(bus.br_taken), 32'(br));
    chk("br_target", bus.br_target, tgt);
    @(posedge clk);
    if (v && !stl && d.ill && !m_flag) begin m_flag = 1'b1; m_ipc = pc; end
    if (rdy) begin
      if (v && !lu) m = {1'b1, d.aluc, d.d1, d.d2, d.st, d.wreg, d.waddr, d.mrd, d.mwr};
      else          m = '0;
    end
    #1;
    chk_regs();
  endtask

  initial begin
    logic [31:0] ins, a, b;
    for (int i = 0; i < 64; i++) begin r_tab[i] = 5'd0; i_tab[i] = 5'd0; end
    r_tab[6'h20] = 5'd1; r_tab[6'h21] = 5'd1; r_tab[6'h22] = 5'd2; r_tab[6'h23] = 5'd2;
    r_tab[6'h24] = 5'd3; r_tab[6'h25] = 5'd4; r_tab[6'h26] = 5'd5;
    r_tab[6'h00] = 5'd6; r_tab[6'h02] = 5'd7; r_tab[6'h03] = 5'd8;
    i_tab[6'h08] = 5'd10; i_tab[6'h09] = 5'd10; i_tab[6'h0C] = 5'd11; i_tab[6'h0D] = 5'd12;
    i_tab[6'h0E] = 5'd13; i_tab[6'h23] = 5'd14; i_tab[6'h2B] = 5'd15; i_tab[6'h04] = 5'd16;
    i_tab[6'h05] = 5'd17; i_tab[6'h0F] = 5'd18;
    fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h00, 6'h02, 6'h03};
    ops = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h3F};

    //          ins                          pc        a        b     aluc  d1           d2     wreg waddr br tgt
    tv[0]  = '{enc_i(8, 8, 9, 16'hFFFC),   32'h200, 32'd10,  32'd0,  5'd10, 32'd10,  32'hFFFF_FFFC, 1'b1, 5'd9,  1'b0, 32'h0};
    tv[1]  = '{enc_i(4, 8, 9, 16'd3),      32'h100, 32'd5,   32'd5,  5'd16, 32'd5,   32'd5,         1'b0, 5'd0,  1'b1, 32'h110};
    tv[2]  = '{enc_i(4, 8, 9, 16'd3),      32'h100, 32'd5,   32'd6,  5'd16, 32'd5,   32'd6,         1'b0, 5'd0,  1'b0, 32'h110};
    tv[3]  = '{enc_r(0, 9, 10, 4, 0),      32'h204, 32'd77,  32'h55, 5'd6,  32'd4,   32'h55,        1'b1, 5'd10, 1'b0, 32'h0};
    tv[4]  = '{enc_i(15, 0, 11, 16'h1234), 32'h208, 32'd99,  32'd7,  5'd18, 32'd99,  32'h1234,      1'b1, 5'd11, 1'b0, 32'h0};
    tv[5]  = '{enc_r(8, 10, 9, 0, 6'h22),  32'h20C, 32'd20,  32'd3,  5'd2,  32'd20,  32'd3,         1'b1, 5'd9,  1'b0, 32'h0};
    tv[6]  = '{enc_i(13, 9, 8, 16'h8001),  32'h210, 32'd1,   32'd2,  5'd12, 32'd1,   32'h8001,      1'b1, 5'd8,  1'b0, 32'h0};
    tv[7]  = '{enc_i(43, 16, 8, 16'd8),    32'h214, 32'h1000, 32'hAB, 5'd15, 32'h1000, 32'd8,       1'b0, 5'd0,  1'b0, 32'h0};
    tv[8]  = '{enc_i(35, 16, 8, 16'hFFF8), 32'h218, 32'h1000, 32'd0, 5'd14, 32'h1000, 32'hFFFF_FFF8, 1'b1, 5'd8, 1'b0, 32'h0};
    tv[9]  = '{enc_r(8, 9, 0, 0, 6'h20),   32'h21C, 32'd1,   32'd2,  5'd1,  32'd1,   32'd2,         1'b0, 5'd0,  1'b0, 32'h0};
    tv[10] = '{enc_i(5, 1, 2, 16'hFFFF),   32'h40,  32'd1,   32'd2,  5'd17, 32'd1,   32'd2,         1'b0, 5'd0,  1'b1, 32'h40};
    tv[11] = '{enc_i(63, 1, 2, 16'd0),     32'h300, 32'd3,   32'd4,  5'd0,  32'd3,   32'd4,         1'b0, 5'd0,  1'b0, 32'h0};
    tv[12] = '{enc_r(1, 2, 3, 0, 6'h07),   32'h304, 32'd5,   32'd6,  5'd0,  32'd5,   32'd6,         1'b0, 5'd0,  1'b0, 32'h0};

    // Power-on reset
    m = '0; m_flag = 1'b0; m_ipc = 32'd0;
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);
    #3;
    chk_regs();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 13; i++) begin
      step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);
      drive(1'b1, tv[i].ins, tv[i].pc, tv[i].a, tv[i].b, 1'b1);
      #1;
      chk($sformatf("tv%0d_br", i), 32'(bus.br_taken), 32'(tv[i].br));
      if (tv[i].aluc inside {5'd16, 5'd17}) chk($sformatf("tv%0d_tgt", i), bus.br_target, tv[i].tgt);
      step(1'b1, tv[i].ins, tv[i].pc, tv[i].a, tv[i].b, 1'b1);
      chk($sformatf("tv%0d_aluc", i), 32'(bus.ex_aluc), 32'(tv[i].aluc));
      chk($sformatf("tv%0d_d1", i), bus.ex_data1, tv[i].d1);
      chk($sformatf("tv%0d_d2", i), bus.ex_data2, tv[i].d2);
      chk($sformatf("tv%0d_wreg", i), 32'(bus.ex_wreg), 32'(tv[i].wreg));
      chk($sformatf("tv%0d_waddr", i), 32'(bus.ex_waddr), 32'(tv[i].waddr));
    end
`ifdef ILLEGAL_TRAP_EN
    chk("trap_flag", 32'(bus.illegal_flag), 32'd1);
    chk("trap_first_pc", bus.illegal_pc, 32'h300);
`endif

    // Load-use: lw $t0,0($s0) then add $t1,$t0,$t2
    step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);
    step(1'b1, enc_i(35, 16, 8, 16'd0), 32'h400, 32'h1000, 32'd0, 1'b1);
    drive(1'b1, enc_r(8, 10, 9, 0, 6'h20), 32'h404, 32'd3, 32'd4, 1'b1);
    #1; chk("lu_stall", 32'(bus.id_stall), 32'd1);
    step(1'b1, enc_r(8, 10, 9, 0, 6'h20), 32'h404, 32'd3, 32'd4, 1'b1);
    chk("lu_bubble", 32'(bus.ex_valid), 32'd0);
    drive(1'b1, enc_r(8, 10, 9, 0, 6'h20), 32'h404, 32'd3, 32'd4, 1'b1);
    #1; chk("lu_release", 32'(bus.id_stall), 32'd0);
    step(1'b1, enc_r(8, 10, 9, 0, 6'h20), 32'h404, 32'd3, 32'd4, 1'b1);
    chk("lu_issue_v", 32'(bus.ex_valid), 32'd1);
    chk("lu_issue_aluc", 32'(bus.ex_aluc), 32'd1);

    // Downstream stall for 3 cycles with a taken beq waiting in ID
    step(1'b1, enc_i(4, 8, 9, 16'd3), 32'h100, 32'd5, 32'd5, 1'b1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, enc_i(4, 8, 9, 16'd3), 32'h104, 32'd7, 32'd7, 1'b0);
      #1;
      chk("hold_stall", 32'(bus.id_stall), 32'd1);
      chk("hold_no_br", 32'(bus.br_taken), 32'd0);
      step(1'b1, enc_i(4, 8, 9, 16'd3), 32'h104, 32'd7, 32'd7, 1'b0);
      chk("hold_aluc", 32'(bus.ex_aluc), 32'd16);
      chk("hold_d1", bus.ex_data1, 32'd5);
    end
    step(1'b1, enc_i(4, 8, 9, 16'd3), 32'h104, 32'd7, 32'd7, 1'b1);

    // Randomized run against the model
    for (int n = 0; n < 400; n++) begin
      int sel;
      sel = $urandom_range(0, 15);
      if (sel == 0)     ins = $urandom;
      else if (sel < 8) ins = enc_r($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                                    $urandom_range(0, 31), int'(fns[$urandom_range(0, 9)]));
      else              ins = enc_i(int'(ops[$urandom_range(0, 10)]), $urandom_range(0, 3),
                                    $urandom_range(0, 3), 16'($urandom));
      a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 3));
      b = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 3));
      step($urandom_range(0, 9) < 9, ins, $urandom & 32'hFFFF_FFFC, a, b, $urandom_range(0, 9) < 8);
    end

    // Asynchronous reset mid-run with a valid instruction in ID/EX
    step(1'b1, enc_i(8, 8, 9, 16'hFFFC), 32'h500, 32'd10, 32'd0, 1'b1);
    chk("pre_rst_valid", 32'(bus.ex_valid), 32'd1);
    #2; rst = 1'b0; #1;
    chk("rst_valid", 32'(bus.ex_valid), 32'd0);
    chk("rst_aluc", 32'(bus.ex_aluc), 32'd0);
    chk("rst_d2", bus.ex_data2, 32'd0);
    chk("rst_wreg", 32'(bus.ex_wreg), 32'd0);
    m = '0; m_flag = 1'b0; m_ipc = 32'd0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);
    chk("post_rst_stall", 32'(bus.id_stall), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
